// File: rtl/me_search_engine.sv
// ---------------------------------------------------------------------------
// me_search_engine
//
// Purpose:
//   Walks a raster of search positions for motion estimation. One vector of
//   per-partition SADs arrives per position from the SAD tree. For each
//   partition the block keeps the minimum SAD and the (col,row) where it was
//   first seen. The stride (1, 2 or 4) is latched on start. The block stops
//   after the last raster position and pulses done for one cycle.
//
// Optional feature (macro EARLY_TERM_EN):
//   Adds early_thr/early_stop. The search ends early when an accepted
//   partition-0 SAD is below early_thr.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   start                one-cycle pulse, starts a search (IDLE only)
//   step_log2            stride = 1<<step_log2 (3 treated as 2), latched on start
//   sad_valid, sad_in    SAD vector for the position shown on the counters
//   early_thr            (EARLY_TERM_EN) early-stop threshold on partition 0
//   busy                 high while walking the raster
//   done                 one-cycle completion pulse
//   early_stop           (EARLY_TERM_EN) set when the search ended early
//   search_column_count  column the next accepted SAD refers to
//   search_row_count     row the next accepted SAD refers to
//   best_sad/col/row     per-partition minimum SAD and its position
//   dbg_state_o          current FSM state, for checkers
//
// Handshake: sad_in is consumed on a rising clk edge where sad_valid=1 and
//   the FSM is in RUN. There is no back-pressure. sad_valid is ignored in
//   IDLE and DONE, and start is ignored outside IDLE.
// ---------------------------------------------------------------------------
module me_search_engine #(
  parameter int NUM_PART = 16,
  parameter int SAD_W    = 16,
  parameter int RANGE_X  = 32,
  parameter int RANGE_Y  = 64,
  localparam int CW      = $clog2(RANGE_X),
  localparam int RW      = $clog2(RANGE_Y)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                step_log2,
  input  logic                      sad_valid,
  input  logic [NUM_PART*SAD_W-1:0] sad_in,
`ifdef EARLY_TERM_EN
  input  logic [SAD_W-1:0]          early_thr,
  output logic                      early_stop,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [CW-1:0]             search_column_count,
  output logic [RW-1:0]             search_row_count,
  output logic [NUM_PART*SAD_W-1:0] best_sad,
  output logic [NUM_PART*CW-1:0]    best_col,
  output logic [NUM_PART*RW-1:0]    best_row,
  output logic [1:0]                dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        stride_log2_q, stride_log2_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [SAD_W-1:0]  best_sad_q [NUM_PART];
  logic [SAD_W-1:0]  best_sad_d [NUM_PART];
  logic [CW-1:0]     best_col_q [NUM_PART];
  logic [CW-1:0]     best_col_d [NUM_PART];
  logic [RW-1:0]     best_row_q [NUM_PART];
  logic [RW-1:0]     best_row_d [NUM_PART];
  logic              early_stop_q, early_stop_d;

  // Sums are one bit wider so a stride of 4 on a 4-wide range cannot overflow.
  logic [CW:0]       stride_x, col_sum;
  logic [RW:0]       stride_y, row_sum;
  logic              col_wrap, row_wrap;
  logic              start_ok, accept, early_hit, finish;

  assign stride_x = {{CW{1'b0}}, 1'b1} << stride_log2_q;
  assign stride_y = {{RW{1'b0}}, 1'b1} << stride_log2_q;
  assign col_sum  = {1'b0, col_q} + stride_x;
  assign row_sum  = {1'b0, row_q} + stride_y;
  assign col_wrap = (col_sum >= (CW+1)'(RANGE_X));
  assign row_wrap = (row_sum >= (RW+1)'(RANGE_Y));

  assign start_ok = (state_q == ST_IDLE) && start;
  assign accept   = (state_q == ST_RUN) && sad_valid;

`ifdef EARLY_TERM_EN
  // The compare is strict and unsigned, so a threshold of 0 never fires.
  assign early_hit = (sad_in[SAD_W-1:0] < early_thr);
`else
  assign early_hit = 1'b0;
`endif

  // Last raster position is (RANGE_X-stride, RANGE_Y-stride): both sums wrap.
  assign finish = accept && ((col_wrap && row_wrap) || early_hit);

  always_comb begin
    state_d       = state_q;
    stride_log2_d = stride_log2_q;
    col_d         = col_q;
    row_d         = row_q;
    early_stop_d  = early_stop_q;
    for (int p = 0; p < NUM_PART; p++) begin
      best_sad_d[p] = best_sad_q[p];
      best_col_d[p] = best_col_q[p];
      best_row_d[p] = best_row_q[p];
    end

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (finish) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start_ok) begin
      stride_log2_d = (step_log2 == 2'd3) ? 2'd2 : step_log2;
      col_d         = '0;
      row_d         = '0;
      early_stop_d  = 1'b0;
      for (int p = 0; p < NUM_PART; p++) begin
        best_sad_d[p] = '1;
        best_col_d[p] = '0;
        best_row_d[p] = '0;
      end
    end else if (accept) begin
      // A strict compare keeps the earliest raster position on ties.
      for (int p = 0; p < NUM_PART; p++) begin
        if (sad_in[p*SAD_W +: SAD_W] < best_sad_q[p]) begin
          best_sad_d[p] = sad_in[p*SAD_W +: SAD_W];
          best_col_d[p] = col_q;
          best_row_d[p] = row_q;
        end
      end
      if (finish) begin
        col_d = '0;
        row_d = '0;
        if (early_hit) early_stop_d = 1'b1;
      end else if (col_wrap) begin
        col_d = '0;
        row_d = row_sum[RW-1:0];
      end else begin
        col_d = col_sum[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      stride_log2_q <= 2'd0;
      col_q         <= '0;
      row_q         <= '0;
      early_stop_q  <= 1'b0;
      for (int p = 0; p < NUM_PART; p++) begin
        best_sad_q[p] <= '1;
        best_col_q[p] <= '0;
        best_row_q[p] <= '0;
      end
    end else begin
      state_q       <= state_d;
      stride_log2_q <= stride_log2_d;
      col_q         <= col_d;
      row_q         <= row_d;
      early_stop_q  <= early_stop_d;
      for (int p = 0; p < NUM_PART; p++) begin
        best_sad_q[p] <= best_sad_d[p];
        best_col_q[p] <= best_col_d[p];
        best_row_q[p] <= best_row_d[p];
      end
    end
  end

  assign busy                = (state_q == ST_RUN);
  assign done                = (state_q == ST_DONE);
  assign search_column_count = col_q;
  assign search_row_count    = row_q;
  assign dbg_state_o         = state_q;
`ifdef EARLY_TERM_EN
  assign early_stop          = early_stop_q;
`else
  // early_stop_q only exists to keep one register set for both builds.
  logic unused_early;
  assign unused_early = early_stop_q;
`endif

  for (genvar g = 0; g < NUM_PART; g++) begin : g_pack
    assign best_sad[g*SAD_W +: SAD_W] = best_sad_q[g];
    assign best_col[g*CW +: CW]       = best_col_q[g];
    assign best_row[g*RW +: RW]       = best_row_q[g];
  end

endmodule

// File: doc/me_search_engine.md
Name: me_search_engine

Overview:
Parametrised successor to the basic-layer search sequencing. It consumes one vector of per-partition SADs per search position from the SAD tree, walks a configurable raster of search positions, and tracks the minimum SAD and its motion vector per partition. Partition count, SAD width, window size and subsampling step are generalised. The block sits between the SAD tree and the global ME controller, which issues start and collects the best-MV results on done.

Parameters:
NUM_PART, 16, number of partitions tracked in parallel (channels)
SAD_W, 16, bit width of each SAD value
RANGE_X, 32, search columns; power of two, >=4
RANGE_Y, 64, search rows; power of two, >=4
CW, $clog2(RANGE_X), column index width (derived, not overridden)
RW, $clog2(RANGE_Y), row index width (derived, not overridden)

Ports:
clk  in  1  clock, single domain
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a search
step_log2  in  2  position stride = 1<<step_log2 (0,1,2; 3 treated as 2); sampled on start
sad_valid  in  1  sad_in holds SADs for the current position
sad_in  in  NUM_PART*SAD_W  partition p at [p*SAD_W +: SAD_W]
busy  out  1  high in RUN
done  out  1  one-cycle pulse when search completes
search_column_count  out  CW  column of the position the next sad_valid refers to
search_row_count  out  RW  row of the position the next sad_valid refers to
best_sad  out  NUM_PART*SAD_W  minimum SAD per partition
best_col  out  NUM_PART*CW  column of minimum per partition
best_row  out  NUM_PART*RW  row of minimum per partition

Behaviour:
- Reset (rst_n low at posedge): FSM=IDLE; busy=0, done=0, counters=0, best_sad=all ones, best_col/best_row=0, stride=1. A reset asserted mid-search aborts the search with no done pulse.
- FSM: IDLE -start-> RUN; RUN -last position accepted-> DONE; DONE -> IDLE unconditionally, 1 cycle; done=1 only in DONE.
- On start in IDLE: latch stride; clear counters; best_sad=all ones; best_col/row=0; busy=1 next cycle.
- start in RUN or DONE: ignored. sad_valid in IDLE or DONE: ignored, no state change.
- RUN, sad_valid=1 at edge t: for each p, if sad_in[p] < best_sad[p] (strict), update best_sad/col/row[p] with the current counters. Equal values keep the earlier raster position. Results are visible at t+1.
- Counter advance per accepted SAD: col += stride. If col+stride >= RANGE_X, col wraps to 0 and row += stride. The last position is col=RANGE_X-stride, row=RANGE_Y-stride. Acceptance there moves to DONE and returns counters to 0.
- Positions per search = (RANGE_X/stride)*(RANGE_Y/stride). Defaults give 2048 positions at stride 1 and 128 at stride 4.
- sad_valid may drop in RUN for any number of cycles; counters and bests hold.
- Best outputs hold after done until the next start or reset.
- No arithmetic widening; comparison is unsigned, SAD_W bits.

Optional Feature:
EARLY_TERM_EN. When defined, two ports are added: early_thr (in, SAD_W) and early_stop (out, 1).
- With the macro: in RUN, if an accepted sad_in[0] < early_thr, the bests are updated normally for that position and the FSM goes to DONE next.
  - early_stop=1 together with done; it clears on the next start or reset.
  - early_thr=0 never triggers.
- Without the macro: neither port exists and the full raster always runs.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-RUN -> busy=0, done=0, best_sad[all]=16'hFFFF, counters=0; no done pulse follows.
- Full search, stride 1, defaults: feed 2048 SADs with sad_in[p]=1000 except position (col 5,row 9)=37 for p=3 -> best_sad[3]=37, best_col[3]=5, best_row[3]=9; other partitions=1000 at (0,0); done exactly 1 cycle after 2048th sad_valid.
- Tie-break: partition 0 value 50 at (2,0) and at (7,4) -> best_col[0]=2, best_row[0]=0.
- Stride 4: 128 positions; check counters go 0,4,…,28 then row 4; a minimum at (28,60) -> best (28,60); done after 128th sad_valid.
- Gapped valid plus ignored stimulus: toggle sad_valid 1/0 randomly; pulse start and sad_valid in IDLE and start in RUN -> results match the ungapped run; IDLE sad_valid leaves bests unchanged.
- EARLY_TERM_EN: early_thr=20; at position 10, sad_in[0]=19 -> done and early_stop the cycle after; best_sad[0]=19; counters back to 0.
